// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: default FIFO geometry and the pointer-width derivation.
package sync_fifo_pkg;
  localparam int DATA_W_DEF = 16;
  localparam int DEPTH_DEF  = 16;
  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction
endpackage

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem: DEPTH x DATA_W register array, one write port and one read port, no reset.
// Ports: clk; we_i/waddr_i/wdata_i write port; raddr_i/rdata_o read port.
// The read port is combinational. The owner captures rdata_o into a register
// on the edge that accepts the read, which completes the synchronous read.
module sync_fifo_mem #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  always_ff @(posedge clk)
    if (we_i) mem_q[waddr_i] <= wdata_i;
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: synchronous FIFO with a registered read output and full/empty flags.
// Ports: clk, rstn (async active-low); wr_en/din push; rd_en pops into dout;
// empty/full are decoded from the registered pointers.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic              full
);
  localparam int ADDR_W = addr_w(DEPTH);
  logic [ADDR_W:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] dout_q, dout_d, rd_data;
  logic wr_acc, rd_acc;
  // Pointers carry one extra wrap bit so that full and empty differ only in that bit.
  assign empty  = wr_ptr_q == rd_ptr_q;
  assign full   = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) && (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);
  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;
  assign dout   = dout_q;
  always_comb begin
    wr_ptr_d = wr_acc ? wr_ptr_q + (ADDR_W+1)'(1) : wr_ptr_q;
    rd_ptr_d = rd_acc ? rd_ptr_q + (ADDR_W+1)'(1) : rd_ptr_q;
    dout_d   = rd_acc ? rd_data : dout_q;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      dout_q   <= dout_d;
    end
  // A write and a read that are both accepted never share an address, so no bypass is needed.
  sync_fifo_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
    .clk     (clk),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q[ADDR_W-1:0]),
    .wdata_i (din),
    .raddr_i (rd_ptr_q[ADDR_W-1:0]),
    .rdata_o (rd_data)
  );
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: randomized and directed checks of sync_fifo against a queue model.
module tb_sync_fifo;
  localparam int DW = 16;
  localparam int DEPTH = 16;
  logic clk, rstn, wr_en, rd_en;
  logic [DW-1:0] din, dout;
  logic empty, full;
  int n_tests, n_fail;
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_dout;
  sync_fifo #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rstn  (rstn),
    .wr_en (wr_en),
    .rd_en (rd_en),
    .din   (din),
    .dout  (dout),
    .empty (empty),
    .full  (full)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask
  task automatic chk_all(input string tag);
    chk({tag, ".dout"}, 32'(dout), 32'(m_dout));
    chk({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
    chk({tag, ".full"}, 32'(full), 32'(q.size() == DEPTH));
  endtask
  task automatic step(input string tag, input logic w, input logic r, input logic [DW-1:0] d);
    bit aw, ar;
    wr_en = w;
    rd_en = r;
    din = d;
    aw = w && q.size() < DEPTH;
    ar = r && q.size() != 0;
    @(posedge clk);
    #1;
    if (ar) m_dout = q.pop_front();
    if (aw) q.push_back(d);
    wr_en = 0;
    rd_en = 0;
    chk_all(tag);
  endtask
  initial begin
    n_tests = 0;
    n_fail = 0;
    m_dout = '0;
    rstn = 1;
    wr_en = 0;
    rd_en = 0;
    din = '0;
    #2 rstn = 0;
    wr_en = 1;
    rd_en = 1;
    din = 16'h1234;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk_all("reset");
      #10;
    end
    @(posedge clk);
    #1;
    wr_en = 0;
    rd_en = 0;
    rstn = 1;
    for (int i = 1; i <= 16; i++) step("fill", 1, 0, DW'(i));
    chk("full_after_16", 32'(full), 32'd1);
    step("drop_write", 1, 0, 16'hFFFF);
    for (int i = 1; i <= 16; i++) begin
      step("drain", 0, 1, 16'h0);
      chk("drain_order", 32'(dout), 32'(i));
    end
    chk("empty_after_drain", 32'(empty), 32'd1);
    for (int i = 0; i < 3; i++) step("rd_empty", 0, 1, 16'h0);
    chk("rd_empty_dout", 32'(dout), 32'h10);
    step("w_abcd", 1, 0, 16'hABCD);
    step("r_abcd", 0, 1, 16'h0);
    chk("abcd", 32'(dout), 32'hABCD);
    for (int i = 0; i < 8; i++) step("hold8", 1, 0, DW'(16'h100 + i));
    for (int i = 8; i < 48; i++) begin
      step("stream", 1, 1, DW'(16'h100 + i));
      chk("stream_order", 32'(dout), 32'(16'h100 + i - 8));
      chk("stream_occ", 32'(q.size()), 32'd8);
    end
    while (q.size() < DEPTH) step("to_full", 1, 0, DW'($urandom));
    step("both_full", 1, 1, 16'h5555);
    chk("both_full_nofull", 32'(full), 32'd0);
    while (q.size() != 0) step("to_empty", 0, 1, 16'h0);
    step("both_empty", 1, 1, 16'h6666);
    chk("both_empty_stored", 32'(empty), 32'd0);
    for (int i = 0; i < 300; i++) begin
      if (i == 150) begin
        rstn = 0;
        #2;
        q.delete();
        m_dout = '0;
        chk_all("mid_reset");
        rstn = 1;
      end
      step("rand", ($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 45), DW'($urandom));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 Parameter DATA_W, default 16, width in bits of each stored word.
REQ-002 Parameter DEPTH, default 16, number of storage entries; power of two, at least 2.
REQ-003 Parameter ADDR_W, default log2(DEPTH) = 4, pointer index width; derived, never overridden independently.
REQ-004 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 Port rstn, input, 1, reset; asynchronous, active-low.
REQ-006 Port wr_en, input, 1, write request for the current cycle.
REQ-007 Port rd_en, input, 1, read request for the current cycle.
REQ-008 Port din, input, DATA_W, write data, sampled at the rising edge when a write is accepted.
REQ-009 Port dout, output, DATA_W, registered read data.
REQ-010 Port empty, output, 1, high when the FIFO holds 0 entries.
REQ-011 Port full, output, 1, high when the FIFO holds DEPTH entries.

Function
REQ-012 Write accepted on a rising edge iff wr_en=1 and full=0; din stored at the write pointer, write pointer +1.
REQ-013 Read accepted on a rising edge iff rd_en=1 and empty=0; entry at the read pointer loaded into dout on that edge, read pointer +1.
REQ-014 Read latency: one clock; data valid on dout right after the accepting edge.
REQ-015 dout holds its last value on every cycle with no accepted read, including rd_en=1 while empty.
REQ-016 Write while full is dropped silently: no storage, pointer, or flag change.
REQ-017 Read while empty: no pointer or flag change; dout unchanged.
REQ-018 Pointers are ADDR_W+1 bits; the low ADDR_W bits index storage; the MSB toggles on each wrap past DEPTH-1.
REQ-019 empty = (wr_ptr == rd_ptr) over all ADDR_W+1 bits; derived combinationally from the registered pointers.
REQ-020 full = (low ADDR_W bits equal) AND (MSBs differ); derived combinationally from the registered pointers.
REQ-021 Simultaneous wr_en and rd_en: each is qualified independently by the pre-edge flags per REQ-012 and REQ-013.
REQ-022 If both are accepted, occupancy is unchanged and the flags are unchanged.
REQ-023 Simultaneous wr_en and rd_en while full: the read proceeds and the write is dropped; occupancy becomes DEPTH-1.
REQ-024 Simultaneous wr_en and rd_en while empty: the write proceeds and the read is ignored; occupancy becomes 1, dout unchanged.
REQ-025 Data order is strictly first-in first-out across any number of pointer wraps.
REQ-026 No combinational path from din to dout; no internal state can express occupancy outside 0..DEPTH.

Reset
REQ-027 rstn=0 asynchronously clears both pointers and dout to 0, giving empty=1 and full=0 immediately.
REQ-028 Storage contents need not be cleared; stale entries are never observable after reset.
REQ-029 Reset asserted mid-operation discards all stored entries.
REQ-030 wr_en and rd_en are ignored while rstn=0.
REQ-031 Normal operation resumes on the first rising edge after rstn deasserts.

Structure
REQ-032 Package sync_fifo_pkg holds the default DATA_W and DEPTH constants and the ADDR_W derivation function.
REQ-033 One sub-module, sync_fifo_mem, is natural: DEPTH x DATA_W register array with one write port and one synchronous read port, no reset.
REQ-034 The top level holds the pointers, the flag logic, and the dout register.

Verification
REQ-035 Reset with rstn=0 for 50 ns -> empty=1, full=0, dout=0 throughout, even with wr_en=1.
REQ-036 Write 0x0001..0x0010 (16 words) -> full=1 after the 16th edge; a 17th write of 0xFFFF is dropped; 16 reads return 0x0001..0x0010 in order, then empty=1.
REQ-037 With the FIFO empty, rd_en=1 for 3 cycles -> dout, empty, and pointers unchanged; then write 0xABCD and read -> dout=0xABCD one edge after the read.
REQ-038 Hold 8 entries, then assert wr_en and rd_en together for 40 cycles with an incrementing din -> occupancy stays 8, no flag toggles, output ordering continuous across the wrap.
REQ-039 At full, assert wr_en and rd_en together for one cycle -> oldest word read out, new word dropped, full=0; at empty, the same -> word stored, empty=0, dout unchanged.
REQ-040 50 random-enable writes plus random-pace reads checked against a scoreboard queue -> zero mismatches; flags always match the model occupancy; reset pulse mid-stream -> empty=1 immediately and the model is flushed.
